// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART byte stream to banked BRAM word loader
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int NBANK  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [NBANK-1:0]         en,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic [DATA_W-1:0]        din,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int BYTES  = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       hdr_q, hdr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
`endif

  // The header window is the two previous bytes plus the byte arriving now.
  logic [23:0]       hdr_win;
  logic              hdr_hit;
  logic              word_last;
  logic              addr_last;
  logic [DATA_W-1:0] din_shift;

  assign hdr_win   = {hdr_q, rx_byte};
  assign hdr_hit   = (hdr_win[23:16] == 8'h77) && (hdr_win[7:0] == 8'h0A) &&
                     (hdr_win[15:8] >= 8'h30) && (hdr_win[15:8] < 8'(8'h30 + NBANK));
  assign word_last = (cnt_q == CNT_W'(BYTES - 1));
  assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));
  assign din_shift = DATA_W'({din_q, rx_byte});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      csum_q <= '0;
    end else begin
      err_q  <= err_d;
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef UART_LOADER_CHECKSUM_EN
    err_d   = err_q;
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (hdr_hit) begin
            state_d = S_COLLECT;
            hdr_d   = '0;
            bank_d  = BANK_W'(hdr_win[15:8] - 8'h30);
            cnt_d   = '0;
            addr_d  = '0;
`ifdef UART_LOADER_CHECKSUM_EN
            err_d   = 1'b0;
            csum_d  = '0;
`endif
          end else begin
            hdr_d = hdr_win[15:0];
          end
        end
      end
      S_COLLECT: begin
        if (rx_valid) begin
          din_d = din_shift;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (word_last) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (addr_last) begin
`ifdef UART_LOADER_CHECKSUM_EN
          // A byte arriving with the last write is already the checksum byte.
          if (rx_valid) begin
            if (rx_byte != csum_q) err_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CHECK;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_COLLECT;
          if (rx_valid) begin
            din_d = din_shift;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_byte;
`endif
            if (BYTES == 1) begin
              cnt_d   = '0;
              state_d = S_WRITE;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_byte != csum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we   = (state_q == S_WRITE);
    done = (state_q == S_DONE);
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    for (int i = 0; i < NBANK; i++) begin
      en[i] = we && (bank_q == BANK_W'(i));
    end
  end

  assign addr = addr_q;
  assign din  = din_q;
`ifdef UART_LOADER_CHECKSUM_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed bench with a byte-stream model for uart_mem_loader
module tb_uart_mem_loader;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int NB = 3;
  localparam int BY = DW / 8;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [NB-1:0] en;
  logic          we;
  logic [1:0]    addr;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;
  logic          err;

  uart_mem_loader #(.DATA_W(DW), .DEPTH(DP), .NBANK(NB)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .en(en), .we(we), .addr(addr), .din(din),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: expected writes with the cycle they must appear, plus step
  // functions for busy/err and the cycle of the done pulse.
  typedef struct { int cyc; int bank; int addr; logic [DW-1:0] data; } wexp_t;
  wexp_t         wq[$];
  bit            m_loading = 0, m_wait_ck = 0;
  logic [15:0]   m_win = '0;
  int            m_bank = 0, m_idx = 0, m_addr = 0, m_idle_from = 0;
  logic [DW-1:0] m_word = '0;
  logic [7:0]    m_xor = '0;
  logic          b_old = 0, b_new = 0, e_old = 0, e_new = 0;
  int            b_chg = 0, e_chg = 0, done_cyc = -1;
  logic [DW-1:0] mem_seen [NB][DP];
  int            wr_cnt = 0, done_cnt = 0;

  function automatic logic val_at(input int c, input logic o, input logic n, input int ch);
    return (c >= ch) ? n : o;
  endfunction

  task automatic sched_busy(input int t, input logic v);
    b_old = val_at(t - 1, b_old, b_new, b_chg);
    b_new = v;
    b_chg = t;
  endtask

  task automatic sched_err(input int t, input logic v);
    e_old = val_at(t - 1, e_old, e_new, e_chg);
    e_new = v;
    e_chg = t;
  endtask

  task automatic finish_load(input int t);
    done_cyc    = t;
    m_idle_from = t + 1;
    sched_busy(t, 1'b0);
    m_loading   = 0;
    m_wait_ck   = 0;
  endtask

  task automatic model_byte(input int d, input logic [7:0] b);
    int    dig;
    wexp_t w;
    if (m_loading && m_wait_ck) begin
      if (b != m_xor) sched_err(d + 1, 1'b1);
      finish_load(d + 1);
    end else if (m_loading) begin
      m_word = (m_word << 8) | DW'(b);
      m_xor  = m_xor ^ b;
      m_idx++;
      if (m_idx == BY) begin
        w.cyc = d + 1; w.bank = m_bank; w.addr = m_addr; w.data = m_word;
        wq.push_back(w);
        m_idx = 0;
        m_addr++;
        if (m_addr == DP) begin
          if (CK) m_wait_ck = 1;
          else finish_load(d + 2);
        end
      end
    end else if (d >= m_idle_from) begin
      dig = int'(m_win[7:0]) - 48;
      if (m_win[15:8] == 8'h77 && b == 8'h0A && dig >= 0 && dig < NB) begin
        m_loading = 1; m_wait_ck = 0; m_win = '0; m_bank = dig;
        m_addr = 0; m_idx = 0; m_xor = '0; m_word = '0;
        sched_busy(d + 1, 1'b1);
        sched_err(d + 1, 1'b0);
      end else begin
        m_win = {m_win[7:0], b};
      end
    end
  endtask

  task automatic model_reset(input int d);
    m_loading = 0; m_wait_ck = 0; m_win = '0; m_idle_from = 0;
    while (wq.size() > 0 && wq[wq.size()-1].cyc > d) void'(wq.pop_back());
    if (done_cyc > d) done_cyc = -1;
    sched_busy(d + 1, 1'b0);
    sched_err(d + 1, 1'b0);
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    int d;
    d = cyc;
    rx_valid = v;
    rx_byte  = b;
    if (v) model_byte(d, b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    drive(1'b1, b);
    repeat (gap) drive(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic header(input int dig);
    send(8'h77, 0);
    send(8'(48 + dig), 0);
    send(8'h0A, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset(cyc);
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  wexp_t cw;
  logic  cexp_we;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      cexp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("we", we, cexp_we);
      if (cexp_we) begin
        cw = wq.pop_front();
        chk("en", en, 32'(1) << cw.bank);
        chk("addr", addr, cw.addr);
        chk("din", din, cw.data);
      end else begin
        chk("en_idle", en, 0);
      end
      chk("busy", busy, val_at(cyc, b_old, b_new, b_chg));
      chk("done", done, cyc == done_cyc);
      chk("err", err, val_at(cyc, e_old, e_new, e_chg));
      if (we === 1'b1) begin
        wr_cnt++;
        for (int i = 0; i < NB; i++) if (en[i] === 1'b1) mem_seen[i][addr] = din;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    logic [7:0] pay [8];
    for (int i = 0; i < NB; i++) for (int j = 0; j < DP; j++) mem_seen[i][j] = '0;
    do_reset(3);
    @(negedge clk);
    chk("rst_we", we, 0);    chk("rst_en", en, 0);     chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);  chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;

    // Bank 0 with irregular gaps, good checksum 48
    header(0);
    pay = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    foreach (pay[i]) send(pay[i], i % 3);
    send(8'h48, 0);
    idle(4);
    chk("b_w0", mem_seen[0][0], 16'hABCD);
    chk("b_w1", mem_seen[0][1], 16'h1234);
    chk("b_w3", mem_seen[0][3], 16'h9ABC);
    chk("b_writes", wr_cnt, 4);
    chk("b_done", done_cnt, 1);
    chk("b_err", err, 0);
    chk("b_busy", busy, 0);
    chk("b_addr_kept", addr, 3);

    // Out-of-range banks 7 and NBANK itself are rejected
    header(7); send(8'h11, 0);
    header(3); send(8'h22, 0);
    idle(4);
    chk("c_writes", wr_cnt, 4);
    chk("c_busy", busy, 0);
    chk("c_done", done_cnt, 1);

    // Last bank, back-to-back payload holding header-like bytes, bad checksum (FE expected)
    header(2);
    pay = '{8'h77, 8'h30, 8'h0A, 8'h77, 8'h31, 8'h0A, 8'h00, 8'hFF};
    foreach (pay[i]) send(pay[i], 0);
    send(8'hFF, 0);
    idle(4);
    chk("d_w0", mem_seen[2][0], 16'h7730);
    chk("d_w1", mem_seen[2][1], 16'h0A77);
    chk("d_w2", mem_seen[2][2], 16'h310A);
    chk("d_w3", mem_seen[2][3], 16'h00FF);
    chk("d_writes", wr_cnt, 8);
    chk("d_done", done_cnt, 2);
    chk("d_err", err, CK);

    // Reset after two words, then a full reload of bank 1
    header(1);
    send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0);
    idle(3);
    chk("e_busy", busy, 1);
    chk("e_addr", addr, 2);
    chk("e_din", din, 16'h0C0D);
    chk("e_err_cleared", err, 0);
    do_reset(1);
    @(negedge clk);
    chk("r_addr", addr, 0); chk("r_din", din, 0);   chk("r_busy", busy, 0);
    chk("r_we", we, 0);     chk("r_en", en, 0);     chk("r_done", done, 0);
    @(posedge clk); #1;
    header(1);
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    foreach (pay[i]) send(pay[i], 1);
    send(8'h08, 0);
    idle(4);
    chk("f_w0", mem_seen[1][0], 16'h0102);
    chk("f_w3", mem_seen[1][3], 16'h0708);
    chk("f_writes", wr_cnt, 14);
    chk("f_done", done_cnt, 3);
    chk("f_err", err, 0);
    chk("f_busy", busy, 0);
    chk("f_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
